mmc1_gen: RTL and testbench



---
 rtl/mmc1_gen_pkg.sv | 35 +++
 rtl/mmc1_gen_serial.sv | 59 +++++
 rtl/mmc1_gen.sv | 158 +++++++++++++++
 tb/tb_mmc1_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_gen_pkg.sv
// mmc1_gen_pkg: shared types and constants for the mmc1_gen mapper.
//   reg_idx_t  - internal register selected by CPU A14:A13 on the 5th write
//   prg_mode_t - PRG banking mode (control[3:2])
//   mirror_t   - nametable mirroring mode (control[1:0])
//   CTRL_RST   - control value after reset / bit-7 serial reset
//   CHR_BASE   - start of CHR in the linear SDRAM map
//   WRAM_TAG   - top address bits that mark the WRAM window
package mmc1_gen_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_CHR0 = 2'd1,
        REG_CHR1 = 2'd2,
        REG_PRG  = 2'd3
    } reg_idx_t;

    typedef enum logic [1:0] {
        PRG_32K_A  = 2'd0,
        PRG_32K_B  = 2'd1,
        PRG_FIX_LO = 2'd2,
        PRG_FIX_HI = 2'd3
    } prg_mode_t;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORZ   = 2'd3
    } mirror_t;

    localparam logic [4:0]  CTRL_RST = 5'b01100;
    localparam logic [21:0] CHR_BASE = 22'h200000;
    localparam logic [3:0]  WRAM_TAG = 4'b1111;

endpackage

// File: rtl/mmc1_gen_serial.sv
// mmc1_gen_serial: 5-write serial load port of the MMC1-class mapper.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   ce            - CPU cycle enable
//   prg_a15       - CPU A15 (register port lives at $8000-$FFFF)
//   prg_sel       - CPU A14:A13, target register of the 5th write
//   prg_write     - CPU write strobe
//   prg_din       - CPU write data (bit 7 = port reset, bit 0 = serial data)
//   commit        - strobe: load commit_data into register commit_idx this edge
//   commit_idx    - target register index (mmc1_gen_pkg::reg_idx_t encoding)
//   commit_data   - completed 5-bit value
//   ctrl_reset    - strobe: OR CTRL_RST into control this edge
module mmc1_gen_serial (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       prg_a15,
    input  logic [1:0] prg_sel,
    input  logic       prg_write,
    input  logic [7:0] prg_din,
    output logic       commit,
    output logic [1:0] commit_idx,
    output logic [4:0] commit_data,
    output logic       ctrl_reset
);

    logic [4:0] shift;
    logic [2:0] count;
    logic       last_write;  // previous ce cycle was a $8000+ write
    logic       accept;

    // Strobes are combinational so the parent registers update on the
    // same edge as the qualifying ce cycle.
    always_comb begin
        accept      = ce && prg_write && prg_a15 && !last_write;
        ctrl_reset  = accept && prg_din[7];
        commit      = accept && !prg_din[7] && (count == 3'd4);
        commit_data = {prg_din[0], shift[4:1]};
        commit_idx  = prg_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            count      <= '0;
            last_write <= 1'b0;
        end else if (ce) begin
            // Suppression tracks every $8000+ write, even ones it ignored.
            last_write <= prg_write && prg_a15;
            if (ctrl_reset) begin
                count <= '0;
            end else if (accept) begin
                shift <= commit_data;
                count <= commit ? 3'd0 : count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mmc1_gen.sv
// mmc1_gen: parametrised MMC1-class mapper (SxROM family incl. SUROM/SXROM
// outer banking) translating CPU/PPU addresses into the linear SDRAM map.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   ce          - CPU cycle enable (M2)
//   prg_ain     - CPU address; prg_write / prg_din - CPU write strobe / data
//   prg_aout    - linear PRG ROM or WRAM address; prg_allow - access permitted
//   chr_ain     - PPU address; chr_aout - linear CHR address (base CHR_BASE)
//   vram_a10    - CIRAM A10; vram_ce - CIRAM select (PPU A13)
//   irq         - IRQ request, active high
// Optional feature: define MMC1_GEN_IRQ_TIMER_EN to build the CPU-cycle IRQ
// timer; without it irq is tied low.
module mmc1_gen
    import mmc1_gen_pkg::*;
#(
    parameter int                   PRG_BANK_W  = 4,
    parameter int                   CHR_BANK_W  = 5,
    parameter int                   PRG_OUTER_W = 0,
    parameter int                   WRAM_BANK_W = 0,
    parameter bit                   MMC1A       = 1'b0,
    parameter int                   IRQ_CNT_W   = 30,
    parameter logic [IRQ_CNT_W-1:0] IRQ_TARGET  = 30'h2800000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    input  logic [13:0] chr_ain,
    output logic [21:0] chr_aout,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        irq
);

    localparam logic [1:0] WRAM_MASK = 2'((32'd1 << WRAM_BANK_W) - 32'd1);

    logic [4:0] control, chr0, chr1, prg;
    logic       commit, ctrl_reset;
    logic [1:0] commit_idx;
    logic [4:0] commit_data;

    mmc1_gen_serial u_serial (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .prg_a15     (prg_ain[15]),
        .prg_sel     (prg_ain[14:13]),
        .prg_write   (prg_write),
        .prg_din     (prg_din),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .ctrl_reset  (ctrl_reset)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            control <= CTRL_RST;
            chr0    <= '0;
            chr1    <= '0;
            prg     <= '0;
        end else if (ctrl_reset) begin
            control <= control | CTRL_RST;
        end else if (commit) begin
            case (reg_idx_t'(commit_idx))
                REG_CTRL: control <= commit_data;
                REG_CHR0: chr0    <= commit_data;
                REG_CHR1: chr1    <= commit_data;
                REG_PRG:  prg     <= commit_data;
                default:  ;
            endcase
        end
    end

    logic [4:0]            sel_chr;
    logic [4:0]            prg_outer;
    logic [1:0]            wram_bank;
    logic [PRG_BANK_W-1:0] prg_inner;
    logic [21:0]           prg_bank;
    logic [CHR_BANK_W-1:0] chr_bank;

    always_comb begin
        sel_chr = (control[4] && chr_ain[12]) ? chr1 : chr0;
        // Right shift picks the top PRG_OUTER_W bits; a width of 0 yields 0.
        prg_outer = sel_chr >> (5 - PRG_OUTER_W);
        wram_bank = sel_chr[3:2] & WRAM_MASK;

        case (prg_mode_t'(control[3:2]))
            PRG_FIX_LO: prg_inner = prg_ain[14] ? prg[PRG_BANK_W-1:0] : '0;
            PRG_FIX_HI: prg_inner = prg_ain[14] ? '1 : prg[PRG_BANK_W-1:0];
            default: begin
                prg_inner    = prg[PRG_BANK_W-1:0];
                prg_inner[0] = prg_ain[14];
            end
        endcase
        prg_bank = (22'(prg_outer) << PRG_BANK_W) | 22'(prg_inner);

        if (prg_ain[15]) begin
            prg_aout = (prg_bank << 14) | {8'b0, prg_ain[13:0]};
        end else begin
            prg_aout = {WRAM_TAG, 3'b000, wram_bank, prg_ain[12:0]};
        end

        if (prg_ain[15]) begin
            prg_allow = !prg_write;
        end else begin
            prg_allow = (prg_ain[14:13] == 2'b11) && (MMC1A || !prg[4]);
        end

        if (control[4]) begin
            chr_bank = chr_ain[12] ? chr1[CHR_BANK_W-1:0] : chr0[CHR_BANK_W-1:0];
        end else begin
            chr_bank    = chr0[CHR_BANK_W-1:0];
            chr_bank[0] = chr_ain[12];
        end
        chr_aout = CHR_BASE | (22'(chr_bank) << 12) | {10'b0, chr_ain[11:0]};

        case (mirror_t'(control[1:0]))
            MIR_ONE_LO: vram_a10 = 1'b0;
            MIR_ONE_HI: vram_a10 = 1'b1;
            MIR_VERT:   vram_a10 = chr_ain[10];
            default:    vram_a10 = chr_ain[11];
        endcase
        vram_ce = chr_ain[13];
    end

`ifdef MMC1_GEN_IRQ_TIMER_EN
    logic [IRQ_CNT_W-1:0] irq_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            if (ce) begin
                if (chr0[4]) begin
                    irq_cnt <= '0;
                end else if (irq_cnt != '1) begin
                    irq_cnt <= irq_cnt + 1'b1;
                end
            end
            // Sticky until software sets chr0[4].
            if (chr0[4]) begin
                irq <= 1'b0;
            end else if (irq_cnt == IRQ_TARGET) begin
                irq <= 1'b1;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmc1_gen.sv
module tb_mmc1_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [15:0] prg_ain = '0;
    logic        prg_write = 1'b0;
    logic [7:0]  prg_din = '0;
    logic [13:0] chr_ain = '0;

    logic [21:0] prg_aout, chr_aout, o_prg_aout, o_chr_aout, a_prg_aout, a_chr_aout;
    logic        prg_allow, vram_a10, vram_ce, irq;
    logic        o_prg_allow, o_vram_a10, o_vram_ce, o_irq;
    logic        a_prg_allow, a_vram_a10, a_vram_ce, a_irq;

    always #5 clk = ~clk;

    mmc1_gen u_dut (
        .clk(clk), .reset(reset), .ce(ce), .prg_ain(prg_ain), .prg_write(prg_write),
        .prg_din(prg_din), .prg_aout(prg_aout), .prg_allow(prg_allow), .chr_ain(chr_ain),
        .chr_aout(chr_aout), .vram_a10(vram_a10), .vram_ce(vram_ce), .irq(irq)
    );

    mmc1_gen #(.PRG_OUTER_W(1), .WRAM_BANK_W(2)) u_outer (
        .clk(clk), .reset(reset), .ce(ce), .prg_ain(prg_ain), .prg_write(prg_write),
        .prg_din(prg_din), .prg_aout(o_prg_aout), .prg_allow(o_prg_allow), .chr_ain(chr_ain),
        .chr_aout(o_chr_aout), .vram_a10(o_vram_a10), .vram_ce(o_vram_ce), .irq(o_irq)
    );

    mmc1_gen #(.MMC1A(1'b1)) u_mmc1a (
        .clk(clk), .reset(reset), .ce(ce), .prg_ain(prg_ain), .prg_write(prg_write),
        .prg_din(prg_din), .prg_aout(a_prg_aout), .prg_allow(a_prg_allow), .chr_ain(chr_ain),
        .chr_aout(a_chr_aout), .vram_a10(a_vram_a10), .vram_ce(a_vram_ce), .irq(a_irq)
    );

`ifdef MMC1_GEN_IRQ_TIMER_EN
    logic [21:0] t_prg_aout, t_chr_aout;
    logic        t_prg_allow, t_vram_a10, t_vram_ce, t_irq;

    mmc1_gen #(.IRQ_TARGET(30'd10)) u_timer (
        .clk(clk), .reset(reset), .ce(ce), .prg_ain(prg_ain), .prg_write(prg_write),
        .prg_din(prg_din), .prg_aout(t_prg_aout), .prg_allow(t_prg_allow), .chr_ain(chr_ain),
        .chr_aout(t_chr_aout), .vram_a10(t_vram_a10), .vram_ce(t_vram_ce), .irq(t_irq)
    );
`endif

    // Output selectors used by scoreboard entries.
    localparam int S_PRG = 0, S_ALLOW = 1, S_CHR = 2, S_A10 = 3, S_IRQ = 4;
    localparam int S_OPRG = 5, S_AALLOW = 6, S_VCE = 7, S_TIRQ = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [21:0] exp;
    } exp_t;

    exp_t sb[$];
    logic chk_req = 1'b0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [21:0] actual(input int sel);
        logic [21:0] v;
        v = 'x;
        case (sel)
            S_PRG:    v = prg_aout;
            S_ALLOW:  v = {21'b0, prg_allow};
            S_CHR:    v = chr_aout;
            S_A10:    v = {21'b0, vram_a10};
            S_IRQ:    v = {21'b0, irq};
            S_OPRG:   v = o_prg_aout;
            S_AALLOW: v = {21'b0, a_prg_allow};
            S_VCE:    v = {21'b0, vram_ce};
`ifdef MMC1_GEN_IRQ_TIMER_EN
            S_TIRQ:   v = {21'b0, t_irq};
`endif
            default:  v = 'x;
        endcase
        return v;
    endfunction

    // Monitor: drains the scoreboard whenever the stimulus presents a sample.
    always @(negedge clk) begin
        if (chk_req) begin
            while (sb.size() > 0) begin
                exp_t e;
                logic [21:0] act;
                e = sb.pop_front();
                act = actual(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic probe(input logic [15:0] pa, input logic [13:0] ca,
                         input string name, input int sel, input logic [21:0] exp);
        exp_t e;
        prg_ain = pa;
        chr_ain = ca;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    // One write ce cycle followed by one idle ce cycle (breaks suppression).
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ce = 1'b1; prg_write = 1'b1; prg_ain = a; prg_din = d;
        @(posedge clk); #1;
        prg_write = 1'b0;
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    // Two writes on back-to-back ce cycles, then an idle ce cycle.
    task automatic wr_pair(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2);
        @(posedge clk); #1;
        ce = 1'b1; prg_write = 1'b1; prg_ain = a; prg_din = d1;
        @(posedge clk); #1;
        prg_din = d2;
        @(posedge clk); #1;
        prg_write = 1'b0;
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ce = 1'b1;
        end
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state: control=01100 (mode 11, 8 KB CHR, mirror 0), all banks 0.
        probe(16'h8123, 14'h0000, "rst_prg8",   S_PRG,   22'h000123);
        probe(16'hC000, 14'h0000, "rst_prgC",   S_PRG,   22'h03C000);
        probe(16'h8000, 14'h0000, "rst_allow8", S_ALLOW, 22'd1);
        probe(16'h6ABC, 14'h0000, "rst_wram",   S_PRG,   22'h3C0ABC);
        probe(16'h6000, 14'h0000, "rst_allow6", S_ALLOW, 22'd1);
        probe(16'h4000, 14'h0000, "rst_allow4", S_ALLOW, 22'd0);
        probe(16'h0000, 14'h1234, "rst_chr",    S_CHR,   22'h201234);
        probe(16'h0000, 14'h0800, "rst_mir",    S_A10,   22'd0);
        probe(16'h0000, 14'h2000, "rst_vce",    S_VCE,   22'd1);
        probe(16'h0000, 14'h0000, "rst_irq",    S_IRQ,   22'd0);

        // control <- 01011: mode 10 ($8000 fixed 0, $C000 = prg = 0), mirror by A11.
        load(16'h8000, 5'b01011);
        probe(16'h8010, 14'h0000, "m10_prg8",  S_PRG, 22'h000010);
        probe(16'hC123, 14'h0000, "m10_prgC",  S_PRG, 22'h000123);
        probe(16'h0000, 14'h0800, "mir3_hi",   S_A10, 22'd1);
        probe(16'h0000, 14'h0400, "mir3_lo",   S_A10, 22'd0);

        // Bit-7 reset after two partial bits: control -> 01111, count cleared.
        wr(16'h8000, 8'h01);
        wr(16'h8000, 8'h00);
        wr(16'h8000, 8'h80);
        load(16'hE000, 5'b00011);
        probe(16'h8000, 14'h0000, "rst7_prg8", S_PRG, 22'h00C000);
        probe(16'hC000, 14'h0000, "rst7_prgC", S_PRG, 22'h03C000);

        // Second back-to-back write ignored: five writes leave prg at 3.
        wr_pair(16'hE000, 8'h01, 8'h00);
        wr(16'hE000, 8'h00);
        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h00);
        probe(16'h8000, 14'h0000, "supp_hold", S_PRG, 22'h00C000);
        wr(16'hE000, 8'h00);
        probe(16'h8000, 14'h0000, "supp_done", S_PRG, 22'h014000);

        // prg[4]=1 disables WRAM except on MMC1A.
        load(16'hE000, 5'b10101);
        probe(16'h6000, 14'h0000, "ramdis",       S_ALLOW,  22'd0);
        probe(16'h6000, 14'h0000, "ramdis_mmc1a", S_AALLOW, 22'd1);
        probe(16'h8000, 14'h0000, "ramdis_prg8",  S_PRG,    22'h014000);

        // control 10001: 4 KB CHR, 32 KB PRG, mirror 1. chr0=6, chr1=9.
        load(16'h8000, 5'b10001);
        load(16'hA000, 5'b00110);
        load(16'hC000, 5'b01001);
        probe(16'h0000, 14'h0456, "chr4k_lo",  S_CHR,  22'h206456);
        probe(16'h0000, 14'h1789, "chr4k_hi",  S_CHR,  22'h209789);
        probe(16'h0000, 14'h0000, "mir1",      S_A10,  22'd1);
        probe(16'h8000, 14'h0000, "p32_lo",    S_PRG,  22'h010000);
        probe(16'hC001, 14'h0000, "p32_hi",    S_PRG,  22'h014001);
        probe(16'h6ABC, 14'h0000, "wram_b1",   S_OPRG, 22'h3C2ABC);
        probe(16'h6ABC, 14'h1000, "wram_b2",   S_OPRG, 22'h3C4ABC);

        // SUROM outer bank: 8 KB CHR, chr0=10000, prg=2, mode 11.
        load(16'h8000, 5'b01100);
        load(16'hA000, 5'b10000);
        load(16'hE000, 5'b00010);
        probe(16'h8000, 14'h0000, "outer_prg8", S_OPRG, 22'h048000);
        probe(16'hC000, 14'h0000, "outer_prgC", S_OPRG, 22'h07C000);
        probe(16'h8000, 14'h0000, "plain_prg8", S_PRG,  22'h008000);
        probe(16'hC000, 14'h0000, "plain_prgC", S_PRG,  22'h03C000);

`ifdef MMC1_GEN_IRQ_TIMER_EN
        // chr0 currently 10000 holds the counter. After chr0 <- 0 the gap cycle
        // of the last write is ce #1, then 9 more reach the target of 10.
        load(16'hA000, 5'b00000);
        idle(9);
        probe(16'h0000, 14'h0000, "irq_pre",  S_TIRQ, 22'd0);
        @(posedge clk); #1;
        probe(16'h0000, 14'h0000, "irq_set",  S_TIRQ, 22'd1);
        load(16'hA000, 5'b10000);
        probe(16'h0000, 14'h0000, "irq_clr",  S_TIRQ, 22'd0);
        idle(12);
        probe(16'h0000, 14'h0000, "irq_hold", S_TIRQ, 22'd0);
`endif
        probe(16'h0000, 14'h0000, "irq_off", S_IRQ, 22'd0);

        // Reset mid-sequence discards partial bits and clears chr0.
        wr(16'hA000, 8'h01);
        wr(16'hA000, 8'h01);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        load(16'hE000, 5'b00111);
        probe(16'h8000, 14'h0000, "mid_rst_prg", S_PRG, 22'h01C000);
        probe(16'h0000, 14'h0000, "mid_rst_chr", S_CHR, 22'h200000);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
